mini68k_sequencer: RTL and testbench

Parametrised multi-cycle control sequencer for the Mini68k core. It takes the instruction word from the prefetch stage, decodes it, and drives the ALU, register file and bus interface through explicit request/acknowledge handshakes. Unlike the fixed-latency control unit, it:
- waits for variable-latency ALU and memory completion;
- supports memory-operand ADD/SUB;
- raises traps for illegal opcodes and bus timeouts, switching to supervisor function code.

---
 rtl/mini68k_ctl_pkg.sv | 31 +++
 rtl/mini68k_bus_timer.sv | 27 ++
 rtl/mini68k_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_mini68k_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mini68k_ctl_pkg.sv
// Mini68k sequencer shared types and constants.
// States, opcodes, ALU codes, function codes and trap vectors.
package mini68k_ctl_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_MEM_RD,
    S_EXECUTE,
    S_ALU_WAIT,
    S_MEM_WR,
    S_WRITEBACK,
    S_TRAP
  } state_t;

  localparam logic [3:0] OP_IMM   = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b1101;
  localparam logic [3:0] OP_SUB   = 4'b1001;
  localparam logic [3:0] OP_MISC  = 4'b0100;
  localparam logic [3:0] OP_MOVEA = 4'b0010;

  localparam int ALU_ADD = 0;
  localparam int ALU_SUB = 1;

  localparam logic [2:0] FC_USER  = 3'b010;
  localparam logic [2:0] FC_SUPER = 3'b110;

  localparam int VEC_BUSERR  = 2;
  localparam int VEC_ILLEGAL = 4;

endpackage

// File: rtl/mini68k_bus_timer.sv
// Bus-cycle watchdog: clears to zero, counts enabled cycles,
// flags expiry on the last permitted cycle of a bus transfer.
module mini68k_bus_timer #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [7:0] count;

  assign expired = (count == 8'(LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/mini68k_sequencer.sv
// Mini68k multi-cycle control sequencer with variable-latency
// ALU/bus handshakes, memory-operand ADD/SUB and trap handling.
module mini68k_sequencer
  import mini68k_ctl_pkg::*;
#(
  parameter int IR_W        = 16,
  parameter int REG_BITS    = 3,
  parameter int ALU_OP_W    = 4,
  parameter int BUS_TIMEOUT = 15,
  parameter int VEC_W       = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IR_W-1:0]     ir,
  input  logic                ir_valid,
  output logic                ir_consume,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                alu_start,
  input  logic                alu_done,
  output logic [REG_BITS-1:0] reg_sel,
  output logic                is_addr_reg,
  output logic                reg_we,
  output logic                mem_req,
  output logic                mem_we,
  input  logic                mem_ack,
  output logic                trap,
  output logic [VEC_W-1:0]    trap_vec,
  output logic [2:0]          fc,
  output logic                busy
);

  state_t state, nstate;

  logic [3:0] opc;
  logic       is_arith, is_imm, is_misc, is_movea;
  logic       ind;

  logic       movea_q, wrmem_q, nowe_q;
  logic       tmr_clr, tmr_en, tmr_exp;

  logic [ALU_OP_W-1:0] alu_op_q;
  logic [REG_BITS-1:0] reg_sel_q;
  logic                addr_q;
  logic [VEC_W-1:0]    vec_q;
  logic [2:0]          fc_q;

  logic unused_ir;
  assign unused_ir = ^{ir[7:6], ir[2:0]};

  assign opc      = ir[IR_W-1 -: 4];
  assign is_arith = (opc == OP_ADD) || (opc == OP_SUB);
  assign is_imm   = (opc == OP_IMM);
  assign is_misc  = (opc == OP_MISC);
  assign is_movea = (opc == OP_MOVEA);
  assign ind      = (ir[5:3] == 3'b010);

  assign alu_op      = alu_op_q;
  assign reg_sel     = reg_sel_q;
  assign is_addr_reg = addr_q;
  assign trap_vec    = vec_q;
  assign fc          = fc_q;
  assign busy        = (state != S_FETCH);

  mini68k_bus_timer #(
    .LIMIT(BUS_TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expired(tmr_exp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
    end else begin
      state <= nstate;
    end
  end

  always_comb begin
    nstate     = state;
    alu_start  = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    reg_we     = 1'b0;
    ir_consume = 1'b0;
    trap       = 1'b0;
    tmr_clr    = 1'b1;
    tmr_en     = 1'b0;
    unique case (state)
      S_FETCH: begin
        if (ir_valid) nstate = S_DECODE;
      end
      S_DECODE: begin
        unique case (1'b1)
          is_arith: nstate = ind ? S_MEM_RD : S_EXECUTE;
          is_imm:   nstate = S_EXECUTE;
          is_misc:  nstate = S_WRITEBACK;
          is_movea: nstate = S_MEM_RD;
          default:  nstate = S_TRAP;
        endcase
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        tmr_clr = 1'b0;
        tmr_en  = !mem_ack;
        // ack wins over expiry on the final permitted cycle
        if (mem_ack) begin
          nstate = movea_q ? S_WRITEBACK : S_EXECUTE;
        end else if (tmr_exp) begin
          nstate = S_TRAP;
        end
      end
      S_EXECUTE: begin
        alu_start = 1'b1;
        nstate    = S_ALU_WAIT;
      end
      S_ALU_WAIT: begin
        if (alu_done) begin
          nstate = wrmem_q ? S_MEM_WR : S_WRITEBACK;
        end
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        tmr_clr = 1'b0;
        tmr_en  = !mem_ack;
        if (mem_ack) begin
          nstate = S_WRITEBACK;
        end else if (tmr_exp) begin
          nstate = S_TRAP;
        end
      end
      S_WRITEBACK: begin
        reg_we     = !nowe_q;
        ir_consume = 1'b1;
        nstate     = S_FETCH;
      end
      S_TRAP: begin
        trap       = 1'b1;
        ir_consume = 1'b1;
        nstate     = S_FETCH;
      end
      default: nstate = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_op_q  <= '0;
      reg_sel_q <= '0;
      addr_q    <= 1'b0;
      movea_q   <= 1'b0;
      wrmem_q   <= 1'b0;
      nowe_q    <= 1'b0;
    end else if (state == S_DECODE) begin
      unique case (1'b1)
        is_arith: begin
          alu_op_q  <= (opc == OP_SUB) ? ALU_OP_W'(ALU_SUB)
                                       : ALU_OP_W'(ALU_ADD);
          reg_sel_q <= ir[9 +: REG_BITS];
          addr_q    <= 1'b0;
        end
        is_imm: begin
          alu_op_q <= ir[8 +: ALU_OP_W];
        end
        is_movea: begin
          reg_sel_q <= ir[9 +: REG_BITS];
          addr_q    <= 1'b1;
        end
        default: ;
      endcase
      movea_q <= is_movea;
      wrmem_q <= is_arith && ind && ir[8];
      nowe_q  <= is_misc || (is_arith && ind && ir[8]);
    end
  end

  // fc is sticky supervisor once any trap has been taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q <= '0;
      fc_q  <= FC_USER;
    end else if (nstate == S_TRAP && state != S_TRAP) begin
      vec_q <= (state == S_DECODE) ? VEC_W'(VEC_ILLEGAL)
                                   : VEC_W'(VEC_BUSERR);
      fc_q  <= FC_SUPER;
    end
  end

endmodule

// File: tb/tb_mini68k_sequencer.sv
// Scoreboard bench for mini68k_sequencer: directed instructions,
// expectations queued at issue, checked by a monitor at retire.
module tb_mini68k_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] ir = '0;
  logic        ir_valid = 1'b0;
  logic        ir_consume;
  logic [3:0]  alu_op;
  logic        alu_start;
  logic        alu_done = 1'b0;
  logic [2:0]  reg_sel;
  logic        is_addr_reg;
  logic        reg_we;
  logic        mem_req;
  logic        mem_we;
  logic        mem_ack;
  logic        trap;
  logic [3:0]  trap_vec;
  logic [2:0]  fc;
  logic        busy;

  logic ack_r = 1'b0;
  logic stray_ack = 1'b0;
  assign mem_ack = ack_r | stray_ack;

  mini68k_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ir         (ir),
    .ir_valid   (ir_valid),
    .ir_consume (ir_consume),
    .alu_op     (alu_op),
    .alu_start  (alu_start),
    .alu_done   (alu_done),
    .reg_sel    (reg_sel),
    .is_addr_reg(is_addr_reg),
    .reg_we     (reg_we),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_ack    (mem_ack),
    .trap       (trap),
    .trap_vec   (trap_vec),
    .fc         (fc),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         trap;
    int         vec;
    int         we;
    int         fc;
    int         alu;
    int         rd;
    int         wr;
    int         lat;
    logic       chk_op;
    int         op;
    logic       chk_sel;
    int         sel;
    int         addr;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  int n_vec = 0;
  int n_bad = 0;
  int n_cons = 0;

  int rd_lat = 0;
  int wr_lat = 0;
  int alu_lat = 1;
  logic stray_en = 1'b0;

  task automatic chk(input string nm, input int act, input int expv);
    n_vec++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  function automatic exp_t mk(
    input int t, input int v, input int w, input int f,
    input int a, input int r, input int wr, input int l,
    input logic co, input int o,
    input logic cs, input int s, input int ad);
    exp_t x;
    x.trap = t; x.vec = v; x.we = w; x.fc = f;
    x.alu = a; x.rd = r; x.wr = wr; x.lat = l;
    x.chk_op = co; x.op = o;
    x.chk_sel = cs; x.sel = s; x.addr = ad;
    return x;
  endfunction

  // memory responder: ack during the Nth cycle of mem_req, 0 = never
  initial forever begin
    @(posedge clk); #1;
    if (rst_n && mem_req) begin
      int lat;
      lat = mem_we ? wr_lat : rd_lat;
      if (lat != 0) begin
        repeat (lat - 1) begin @(posedge clk); #1; end
        ack_r = 1'b1;
        @(posedge clk); #1;
        ack_r = 1'b0;
      end else begin
        while (mem_req) begin @(posedge clk); #1; end
      end
    end
  end

  // ALU responder: done alu_lat cycles after start, optional stray ack
  initial forever begin
    @(posedge clk); #1;
    if (rst_n && alu_start) begin
      for (int i = 0; i < alu_lat; i++) begin
        @(posedge clk); #1;
        stray_ack = stray_en && (i == 5);
      end
      stray_ack = 1'b0;
      alu_done = 1'b1;
      @(posedge clk); #1;
      alu_done = 1'b0;
    end
  end

  int m_alu, m_rd, m_wr, m_we, m_trap, m_busy, m_vec, m_op;

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      m_alu = 0; m_rd = 0; m_wr = 0; m_we = 0;
      m_trap = 0; m_busy = 0; m_vec = 0; m_op = 0;
    end else begin
      m_alu  += int'(alu_start);
      m_rd   += int'(mem_req && !mem_we);
      m_wr   += int'(mem_req && mem_we);
      m_we   += int'(reg_we);
      m_busy += int'(busy);
      if (alu_start) m_op = int'(alu_op);
      if (trap) begin
        m_trap++;
        m_vec = int'(trap_vec);
      end
      if (ir_consume) begin
        n_cons++;
        if (exp_q.size() == 0) begin
          chk("unexpected_consume", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("trap_pulses", m_trap, e.trap);
          if (e.trap != 0) chk("trap_vec", m_vec, e.vec);
          chk("reg_we_pulses", m_we, e.we);
          chk("fc", int'(fc), e.fc);
          chk("alu_start_pulses", m_alu, e.alu);
          chk("mem_rd_cycles", m_rd, e.rd);
          chk("mem_wr_cycles", m_wr, e.wr);
          chk("latency", m_busy + 1, e.lat);
          chk("mem_req_at_retire", int'(mem_req), 0);
          if (e.chk_op) chk("alu_op", m_op, e.op);
          if (e.chk_sel) begin
            chk("reg_sel", int'(reg_sel), e.sel);
            chk("is_addr_reg", int'(is_addr_reg), e.addr);
          end
        end
        m_alu = 0; m_rd = 0; m_wr = 0; m_we = 0;
        m_trap = 0; m_busy = 0; m_vec = 0;
      end
    end
  end

  task automatic run(input logic [15:0] i, input int rl,
                     input int wl, input int al,
                     input logic stray, input exp_t x);
    logic got;
    rd_lat = rl; wr_lat = wl; alu_lat = al; stray_en = stray;
    exp_q.push_back(x);
    @(negedge clk);
    ir = i;
    ir_valid = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 300 && !got; k++) begin
      @(posedge clk); #1;
      if (ir_consume) got = 1'b1;
    end
    if (!got) begin
      chk("consume_timeout", 0, 1);
      void'(exp_q.pop_back());
    end
    @(negedge clk);
    ir_valid = 1'b0;
  endtask

  initial begin
    int c0;
    logic seen;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_mem_req", int'(mem_req), 0);
    chk("rst_fc", int'(fc), 2);
    chk("rst_trap_vec", int'(trap_vec), 0);
    chk("rst_alu_op", int'(alu_op), 0);
    chk("rst_reg_sel", int'(reg_sel), 0);
    chk("rst_strobes",
        int'({alu_start, reg_we, ir_consume, trap}), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run(16'hD203, 0, 0, 1, 1'b0,
        mk(0, 0, 1, 2, 1, 0, 0, 5, 1'b1, 0, 1'b1, 1, 0));
    run(16'h9313, 3, 2, 1, 1'b0,
        mk(0, 0, 0, 2, 1, 3, 2, 10, 1'b1, 1, 1'b1, 1, 0));
    run(16'hD203, 0, 0, 20, 1'b1,
        mk(0, 0, 1, 2, 1, 0, 0, 24, 1'b1, 0, 1'b1, 1, 0));
    run(16'h0A00, 0, 0, 1, 1'b0,
        mk(0, 0, 1, 2, 1, 0, 0, 5, 1'b1, 10, 1'b0, 0, 0));
    run(16'h4E71, 0, 0, 1, 1'b0,
        mk(0, 0, 0, 2, 0, 0, 0, 3, 1'b0, 0, 1'b0, 0, 0));
    run(16'h2410, 2, 0, 1, 1'b0,
        mk(0, 0, 1, 2, 0, 2, 0, 5, 1'b0, 0, 1'b1, 2, 1));
    run(16'h2410, 15, 0, 1, 1'b0,
        mk(0, 0, 1, 2, 0, 15, 0, 18, 1'b0, 0, 1'b1, 2, 1));
    run(16'hF000, 0, 0, 1, 1'b0,
        mk(1, 4, 0, 6, 0, 0, 0, 3, 1'b0, 0, 1'b0, 0, 0));
    run(16'h2410, 0, 0, 1, 1'b0,
        mk(1, 2, 0, 6, 0, 15, 0, 18, 1'b0, 0, 1'b1, 2, 1));

    rd_lat = 0;
    @(negedge clk);
    ir = 16'h2410;
    ir_valid = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(posedge clk); #1;
      if (mem_req) seen = 1'b1;
    end
    chk("reset_test_mem_req_seen", int'(seen), 1);
    @(negedge clk);
    ir_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midop_rst_mem_req", int'(mem_req), 0);
    chk("midop_rst_busy", int'(busy), 0);
    chk("midop_rst_fc", int'(fc), 2);
    c0 = n_cons;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("no_consume_after_rst", n_cons - c0, 0);

    run(16'hD203, 0, 0, 1, 1'b0,
        mk(0, 0, 1, 2, 1, 0, 0, 5, 1'b1, 0, 1'b1, 1, 0));

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
